global_ldst_sequencer: RTL and testbench
========================================

# global_ldst_sequencer

Sequences one unit-stride vector load/store at a time into full-beat memory bursts for the shared AXI port of the multi-cluster vector unit. Takes base address, `vl` and `vtype` (the committed configuration from the global dispatcher) and emits address-channel bursts that never cross a 4 KiB page and never exceed `MaxBurstLen` beats. Limits in-flight bursts to `MaxOutstanding`. Reports completion once every issued burst has retired.

## Interface
- `NrClusters`, default 4: number of clusters; sizes `vlen_cl_t`.
- `AxiDataWidth`, default 512: bits per data beat; `DB = AxiDataWidth/8` bytes.
- `AxiAddrWidth`, default 64: address width.
- `MaxBurstLen`, default 256: maximum beats per burst, power of two, 1–256.
- `MaxOutstanding`, default 8: maximum issued-but-uncompleted bursts.
- `vlen_cl_t`, default `logic`: global vector-length type.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: high only in IDLE.
- `req_addr_i` in AxiAddrWidth: byte base address.
- `req_store_i` in 1: 1 = store, 0 = load.
- `vl_i` in `$bits(vlen_cl_t)`: element count.
- `vtype_i` in `vtype_t`: vsew/vill used.
- `ax_valid_o` out 1: burst request valid.
- `ax_ready_i` in 1: burst request accepted.
- `ax_addr_o` out AxiAddrWidth: DB-aligned burst start.
- `ax_len_o` out 8: beats minus one.
- `ax_size_o` out 3: always `$clog2(DB)`.
- `ax_write_o` out 1: latched `req_store_i`.
- `cmpl_i` in 1: one-cycle pulse, one burst retired.
- `done_o` out 1: one-cycle pulse, request finished.
- `err_o` out 1: one-cycle pulse, request rejected.
- `busy_o` out 1: state != IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE:** when `req_valid_i` is high, the request is accepted.
  - If `vtype_i.vill` is set, or `req_addr_i` is not aligned to `1<<vsew`: pulse `err_o` next cycle, issue no bursts, stay in IDLE.
  - If `vl_i == 0`: pulse `done_o` next cycle, stay in IDLE.
  - Otherwise latch `bytes = vl << vsew` (width `$bits(vlen_cl_t)+3`), `cur = addr & ~(DB-1)`, and `beats_left = ((addr+bytes-1)>>log2DB) - (addr>>log2DB) + 1`, then go to ISSUE.
- **ISSUE:** each burst is `n = min(beats_left, MaxBurstLen, (4096 - cur[11:0])/DB)`.
  - Drive `ax_addr_o = cur`, `ax_len_o = n-1`.
  - `ax_valid_o` is high when `outstanding < MaxOutstanding`.
  - On `ax_valid_o && ax_ready_i`: `cur += n*DB`, `beats_left -= n`, `outstanding++`.
  - When `beats_left` reaches 0, go to DRAIN.
- **DRAIN:** when `outstanding == 0`, pulse `done_o` and go to IDLE.
  - If the last handshake leaves `outstanding` at 0 (same-cycle `cmpl_i`), the `done_o` cycle follows DRAIN entry directly.
- **Outstanding counter:**
  - Width `$clog2(MaxOutstanding+1)`.
  - Handshake and `cmpl_i` in the same cycle leave it unchanged.
  - `cmpl_i` while the counter is 0 is ignored; an assertion flags it.
  - `cmpl_i` is honoured in every state, including IDLE.
- **Handshake:** once `ax_valid_o` rises, `ax_addr_o`, `ax_len_o` and `ax_write_o` stay stable and `ax_valid_o` stays high until accepted.
- **Reset mid-operation:** returns to IDLE, clears `outstanding`, drops `ax_valid_o` immediately; in-flight bursts are abandoned.

## Timing
- Reset values: `req_ready_o=1`, `busy_o=0`, `ax_valid_o=0`, `ax_addr_o=0`, `ax_len_o=0`, `ax_write_o=0`, `ax_size_o=$clog2(DB)` (constant), `done_o=0`, `err_o=0`.
- Request accepted in cycle N → first `ax_valid_o` in N+1 (registered burst fields).
- Back-to-back bursts: after a handshake in cycle M, the next burst is valid in M+1.
- `done_o`/`err_o` are registered; they pulse exactly one cycle, and never in the same cycle as `req_ready_o` is low in IDLE.
- `req_ready_o` is combinational from state only.

## Structure
- `ara_pkg`:
  - `ldst_seq_state_e` (IDLE/ISSUE/DRAIN)
  - `localparam PageBytes = 4096`
  - a burst request struct `{addr, len, size, write}` for reuse by per-cluster address generators.
- `vtype_t`/`vew_e` come from `rvv_pkg`.
- One sub-module, `burst_len_calc`: combinational min of remaining beats, burst cap and beats-to-page-end. It is reused by the cluster-level address generator.

## Test plan
All scenarios use DB=64.
1. `addr=0x1000`, `vl=256`, EW32 → one burst: addr 0x1000, len 15; after `cmpl_i`, `done_o` pulses.
2. `addr=0x1FC0`, `vl=32`, EW64 (256 B) → burst 0x1FC0 len 0, then 0x2000 len 2 on the next cycle; `done_o` after two completions.
3. `MaxBurstLen=16`, `addr=0`, `vl=640`, EW64 (5120 B, 80 beats) → bursts 0x0/15, 0x400/15, 0x800/15, 0xC00/15, 0x1000/15.
4. `MaxOutstanding=2`, `cmpl_i` held low, 4-burst request → exactly two handshakes, then `ax_valid_o` low; one `cmpl_i` releases the third burst.
5. `addr=0x1002`, EW32 → `err_o` pulse, no `ax_valid_o`, `req_ready_o` stays high; `vill=1` behaves the same; `vl=0` → `done_o` pulse only.
6. `ax_ready_i` held low for 5 cycles, then `rst_i` asserted mid-ISSUE → fields stable during the stall; after reset, `ax_valid_o=0`, `busy_o=0`, and a fresh request behaves as in scenario 1.

Source files
------------

// File: rtl/global_ldst_sequencer_pkg.sv
// Shared types for the global load/store sequencer: RVV configuration types and
// the sequencer's own state encoding and burst request layout.
package rvv_pkg;

  typedef enum logic [2:0] {
    EW8  = 3'd0,
    EW16 = 3'd1,
    EW32 = 3'd2,
    EW64 = 3'd3
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'd0,
    LMUL_2 = 3'd1,
    LMUL_4 = 3'd2,
    LMUL_8 = 3'd3
  } vlmul_e;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

endpackage

package ara_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } ldst_seq_state_e;

  localparam int unsigned PageBytes = 4096;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        write;
  } ax_req_t;

endpackage

// File: rtl/global_ldst_sequencer_burst_len_calc.sv
// Burst length for the next address-channel request: the smallest of the beats
// still owed, the burst cap and the beats left before the 4 KiB page boundary.
module burst_len_calc
  import ara_pkg::*;
#(
  parameter int unsigned BeatsW      = 16,
  parameter int unsigned MaxBurstLen = 256,
  parameter int unsigned BeatBytes   = 64
) (
  input  logic [BeatsW-1:0] beats_left,
  input  logic [11:0]       page_off,
  output logic [8:0]        burst_beats
);

  localparam int unsigned Log2Beat = $clog2(BeatBytes);
  localparam int unsigned CmpW     = (BeatsW > 13) ? BeatsW : 13;

  logic [12:0] page_beats;
  logic [12:0] cap;

  always_comb begin
    // page_off is beat-aligned, so the shift is exact
    page_beats = (13'(PageBytes) - {1'b0, page_off}) >> Log2Beat;
    cap        = (13'(MaxBurstLen) < page_beats) ? 13'(MaxBurstLen) : page_beats;
    if (CmpW'(beats_left) < CmpW'(cap)) begin
      burst_beats = 9'(beats_left);
    end else begin
      burst_beats = 9'(cap);
    end
  end

endmodule

// File: rtl/global_ldst_sequencer.sv
// Splits one unit-stride vector load/store into page-safe, capped AXI bursts
// and tracks outstanding bursts until all have retired.
module global_ldst_sequencer
  import ara_pkg::*;
  import rvv_pkg::*;
#(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned AxiDataWidth   = 512,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         vlen_cl_t      = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AxiAddrWidth-1:0]       req_addr_i,
  input  logic                          req_store_i,
  input  logic [$bits(vlen_cl_t)-1:0]   vl_i,
  input  vtype_t                        vtype_i,
  output logic                          ax_valid_o,
  input  logic                          ax_ready_i,
  output logic [AxiAddrWidth-1:0]       ax_addr_o,
  output logic [7:0]                    ax_len_o,
  output logic [2:0]                    ax_size_o,
  output logic                          ax_write_o,
  input  logic                          cmpl_i,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int unsigned DB     = AxiDataWidth / 8;
  localparam int unsigned Log2Db = $clog2(DB);
  localparam int unsigned AW     = AxiAddrWidth;
  localparam int unsigned VlW    = $bits(vlen_cl_t);
  localparam int unsigned BytesW = VlW + 3;
  localparam int unsigned BeatsW = VlW + 4;
  localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);

  if (NrClusters == 0 || MaxBurstLen < 1 || MaxBurstLen > 256 ||
      (MaxBurstLen & (MaxBurstLen - 1)) != 0 || MaxOutstanding == 0) begin : g_param_check
    $error("global_ldst_sequencer: invalid parameterisation");
  end

  ldst_seq_state_e   state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d;
  logic [BeatsW-1:0] beats_q, beats_d;
  logic              write_q, write_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [2:0]        sew;
  logic [2:0]        align_mask;
  logic              req_bad;
  logic [BytesW-1:0] req_bytes;
  logic [AW-1:0]     last_addr;
  logic [AW-1:0]     beat_span;
  logic [BeatsW-1:0] req_beats;
  logic [8:0]        burst_n;
  logic              hs;
  ax_req_t           ax_req;
  logic              unused_bits;

  burst_len_calc #(
    .BeatsW      (BeatsW),
    .MaxBurstLen (MaxBurstLen),
    .BeatBytes   (DB)
  ) i_burst_len_calc (
    .beats_left  (beats_q),
    .page_off    (cur_q[11:0]),
    .burst_beats (burst_n)
  );

  // Request decode: alignment, byte count and total beats spanned
  always_comb begin
    sew        = vtype_i.vsew;
    align_mask = 3'((4'd1 << sew[1:0]) - 4'd1);
    req_bad    = vtype_i.vill | sew[2] | (|(req_addr_i[2:0] & align_mask));
    req_bytes  = {3'b000, vl_i} << sew[1:0];
    last_addr  = req_addr_i + AW'(req_bytes) - AW'(1);
    beat_span  = (last_addr >> Log2Db) - (req_addr_i >> Log2Db) + AW'(1);
    req_beats  = beat_span[BeatsW-1:0];
  end

  assign unused_bits = ^{vtype_i.vma, vtype_i.vta, vtype_i.vlmul, beat_span[AW-1:BeatsW]};

  always_comb begin
    ax_valid_o = (state_q == ISSUE) && (outstanding_q < OutW'(MaxOutstanding));
    hs         = ax_valid_o && ax_ready_i;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    beats_d = beats_q;
    write_d = write_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else if (vl_i == '0) begin
            done_d = 1'b1;
          end else begin
            cur_d   = req_addr_i & ~(AW'(DB) - AW'(1));
            beats_d = req_beats;
            write_d = req_store_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          cur_d   = cur_q + (AW'(burst_n) << Log2Db);
          beats_d = beats_q - BeatsW'(burst_n);
          if (beats_q == BeatsW'(burst_n)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completion arriving with nothing outstanding is dropped, not wrapped
  always_comb begin
    outstanding_d = outstanding_q;
    if (hs && !cmpl_i) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!hs && cmpl_i && outstanding_q != '0) begin
      outstanding_d = outstanding_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      beats_q       <= '0;
      write_q       <= 1'b0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      beats_q       <= beats_d;
      write_q       <= write_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    ax_req.addr  = 64'(cur_q);
    ax_req.len   = (state_q == ISSUE) ? 8'(burst_n - 9'd1) : '0;
    ax_req.size  = 3'(Log2Db);
    ax_req.write = write_q;
  end

  assign ax_addr_o   = ax_req.addr[AW-1:0];
  assign ax_len_o    = ax_req.len;
  assign ax_size_o   = ax_req.size;
  assign ax_write_o  = ax_req.write;
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  cmpl_without_burst: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cmpl_i && !hs && outstanding_q == '0));

endmodule

// File: tb/tb_global_ldst_sequencer.sv
// Scoreboard bench for global_ldst_sequencer (DB=64, 16-beat cap, 2 outstanding).
module tb_global_ldst_sequencer;
  import rvv_pkg::*;

  localparam int unsigned MBL = 16;
  localparam int unsigned MO  = 2;
  localparam int unsigned DBB = 64;
  typedef logic [15:0] vl_t;

  typedef struct {
    longint unsigned addr;
    int unsigned     len;
    bit              write;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        req_store_i;
  vl_t         vl_i;
  vtype_t      vtype_i;
  logic        ax_valid_o;
  logic        ax_ready_i;
  logic [63:0] ax_addr_o;
  logic [7:0]  ax_len_o;
  logic [2:0]  ax_size_o;
  logic        ax_write_o;
  logic        cmpl_i;
  logic        done_o;
  logic        err_o;
  logic        busy_o;

  always #5 clk = ~clk;

  global_ldst_sequencer #(
    .NrClusters     (4),
    .AxiDataWidth   (512),
    .AxiAddrWidth   (64),
    .MaxBurstLen    (MBL),
    .MaxOutstanding (MO),
    .vlen_cl_t      (vl_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_store_i (req_store_i),
    .vl_i        (vl_i),
    .vtype_i     (vtype_i),
    .ax_valid_o  (ax_valid_o),
    .ax_ready_i  (ax_ready_i),
    .ax_addr_o   (ax_addr_o),
    .ax_len_o    (ax_len_o),
    .ax_size_o   (ax_size_o),
    .ax_write_o  (ax_write_o),
    .cmpl_i      (cmpl_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  burst_t exp_q[$];
  int vectors  = 0;
  int errors   = 0;
  int outst    = 0;
  int hs_count = 0;
  int n_done   = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle at the sample point: drive ready/completion, check the address
  // channel against the scoreboard head, then advance to the next sample point.
  task automatic step(input bit rdy, input bit cmpl_en);
    bit hs;
    bit c;
    ax_ready_i = rdy;
    c = cmpl_en && (outst > 0);
    cmpl_i = c;
    check("ax_valid", ax_valid_o, (exp_q.size() > 0 && outst < MO));
    hs = (ax_valid_o === 1'b1) && rdy;
    if (ax_valid_o === 1'b1 && exp_q.size() > 0) begin
      check("ax_addr", ax_addr_o, exp_q[0].addr);
      check("ax_len", ax_len_o, exp_q[0].len);
      check("ax_write", ax_write_o, exp_q[0].write);
      check("ax_size", ax_size_o, 6);
      if (hs) begin
        void'(exp_q.pop_front());
        hs_count++;
        outst++;
      end
    end
    if (c) outst--;
    if (done_o === 1'b1) n_done++;
    if (err_o === 1'b1) n_err++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bursts(input longint unsigned addr, input int unsigned vl,
                             input int unsigned sew, input bit store);
    longint unsigned bytes, cur, beats, page, n;
    burst_t b;
    bytes = longint'(vl) << sew;
    beats = ((addr + bytes - 1) / DBB) - (addr / DBB) + 1;
    cur   = addr & ~longint'(DBB - 1);
    while (beats > 0) begin
      page = (4096 - (cur % 4096)) / DBB;
      n = beats;
      if (n > MBL) n = MBL;
      if (n > page) n = page;
      b.addr  = cur;
      b.len   = int'(n - 1);
      b.write = store;
      exp_q.push_back(b);
      cur   += n * DBB;
      beats -= n;
    end
  endtask

  task automatic send(input longint unsigned addr, input int unsigned vl,
                      input int unsigned sew, input bit vill, input bit store);
    vtype_t vt;
    bit bad;
    vt = '0;
    vt.vill = vill;
    vt.vsew = vew_e'(sew);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_store_i = store;
    vl_i        = vl_t'(vl);
    vtype_i     = vt;
    check("req_ready_idle", req_ready_o, 1);
    step(1, 0);
    req_valid_i = 1'b0;
    bad = vill || ((addr & ((64'd1 << sew) - 1)) != 0);
    if (bad || vl == 0) begin
      check(bad ? "err_pulse" : "done_pulse", bad ? err_o : done_o, 1);
      check(bad ? "err_no_done" : "done_no_err", bad ? done_o : err_o, 0);
      check("reject_ready", req_ready_o, 1);
      check("reject_busy", busy_o, 0);
      step(1, 0);
      check("pulse_len_err", err_o, 0);
      check("pulse_len_done", done_o, 0);
    end else begin
      push_bursts(addr, vl, sew, store);
      check("accept_ready", req_ready_o, 0);
      check("accept_busy", busy_o, 1);
    end
  endtask

  task automatic wait_done(input int limit);
    int start;
    int i;
    start = n_done;
    i = 0;
    while (n_done == start && i < limit) begin
      if (done_o === 1'b1) begin
        check("done_outst", outst, 0);
        check("done_queue", exp_q.size(), 0);
      end
      step(1, 1);
      i++;
    end
    check("done_seen", n_done - start, 1);
    check("done_one_cycle", done_o, 0);
    check("done_ready", req_ready_o, 1);
    check("done_busy", busy_o, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_store_i = 1'b0;
    vl_i = '0;
    vtype_i = '0;
    ax_ready_i = 1'b0;
    cmpl_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_ax_valid", ax_valid_o, 0);
    check("rst_ax_addr", ax_addr_o, 0);
    check("rst_ax_len", ax_len_o, 0);
    check("rst_ax_write", ax_write_o, 0);
    check("rst_ax_size", ax_size_o, 6);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    step(0, 0);

    // single 16-beat burst
    send(64'h1000, 256, 2, 0, 0);
    wait_done(100);
    // page crossing, store
    send(64'h1FC0, 32, 3, 0, 1);
    wait_done(100);
    // burst cap splits 80 beats into five
    send(64'h0, 640, 3, 0, 0);
    wait_done(200);

    // outstanding limit with completions withheld
    send(64'h0, 1024, 2, 0, 0);
    h0 = hs_count;
    repeat (8) step(1, 0);
    check("mo_hold", hs_count - h0, 2);
    step(1, 1);
    repeat (3) step(1, 0);
    check("mo_release", hs_count - h0, 3);
    wait_done(200);

    // rejections and empty request
    send(64'h1002, 4, 2, 0, 0);
    send(64'h1000, 4, 2, 1, 0);
    send(64'h1001, 4, 1, 0, 0);
    send(64'h1000, 0, 2, 0, 0);
    // byte element at odd address
    send(64'h1003, 1, 0, 0, 1);
    wait_done(100);

    // stall then reset mid-ISSUE
    send(64'h1000, 256, 2, 0, 1);
    repeat (5) step(0, 0);
    rst_i = 1'b1;
    ax_ready_i = 1'b0;
    cmpl_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    outst = 0;
    check("midrst_valid", ax_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", req_ready_o, 1);
    send(64'h1000, 256, 2, 0, 0);
    wait_done(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
